// File: rtl/morse_pkg.sv
// Shared symbol encodings, ASCII constants and the five-slot Morse decode used
// by the stream decoder.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_GAP  = 2'b10;
  localparam logic [1:0] SYM_PAD  = 2'b11;

  localparam logic [7:0] ASCII_NULL  = 8'h00;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  localparam logic [9:0] CODE_GAP  = {SYM_GAP, {4{SYM_PAD}}};
  localparam logic [9:0] CODE_NULL = {5{SYM_PAD}};

  typedef struct packed {
    logic       err;
    logic [7:0] ch;
  } morse_char_t;

  // Slot 0 sits in code[9:8]; anything not listed is an unmatched code.
  function automatic morse_char_t morse_decode5(input logic [9:0] code);
    morse_char_t r;
    r.err = 1'b0;
    r.ch  = ASCII_QMARK;
    case (code)
      CODE_GAP:  r.ch = ASCII_SPACE;
      CODE_NULL: r.ch = ASCII_NULL;
      {SYM_DOT,  SYM_DASH, SYM_PAD,  SYM_PAD,  SYM_PAD }: r.ch = "A";
      {SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_PAD }: r.ch = "B";
      {SYM_DASH, SYM_DOT,  SYM_DASH, SYM_DOT,  SYM_PAD }: r.ch = "C";
      {SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_PAD,  SYM_PAD }: r.ch = "D";
      {SYM_DOT,  SYM_PAD,  SYM_PAD,  SYM_PAD,  SYM_PAD }: r.ch = "E";
      {SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_DOT,  SYM_PAD }: r.ch = "F";
      {SYM_DASH, SYM_DASH, SYM_DOT,  SYM_PAD,  SYM_PAD }: r.ch = "G";
      {SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_PAD }: r.ch = "H";
      {SYM_DOT,  SYM_DOT,  SYM_PAD,  SYM_PAD,  SYM_PAD }: r.ch = "I";
      {SYM_DOT,  SYM_DASH, SYM_DASH, SYM_DASH, SYM_PAD }: r.ch = "J";
      {SYM_DASH, SYM_DOT,  SYM_DASH, SYM_PAD,  SYM_PAD }: r.ch = "K";
      {SYM_DOT,  SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_PAD }: r.ch = "L";
      {SYM_DASH, SYM_DASH, SYM_PAD,  SYM_PAD,  SYM_PAD }: r.ch = "M";
      {SYM_DASH, SYM_DOT,  SYM_PAD,  SYM_PAD,  SYM_PAD }: r.ch = "N";
      {SYM_DASH, SYM_DASH, SYM_DASH, SYM_PAD,  SYM_PAD }: r.ch = "O";
      {SYM_DOT,  SYM_DASH, SYM_DASH, SYM_DOT,  SYM_PAD }: r.ch = "P";
      {SYM_DASH, SYM_DASH, SYM_DOT,  SYM_DASH, SYM_PAD }: r.ch = "Q";
      {SYM_DOT,  SYM_DASH, SYM_DOT,  SYM_PAD,  SYM_PAD }: r.ch = "R";
      {SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_PAD,  SYM_PAD }: r.ch = "S";
      {SYM_DASH, SYM_PAD,  SYM_PAD,  SYM_PAD,  SYM_PAD }: r.ch = "T";
      {SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_PAD,  SYM_PAD }: r.ch = "U";
      {SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_PAD }: r.ch = "V";
      {SYM_DOT,  SYM_DASH, SYM_DASH, SYM_PAD,  SYM_PAD }: r.ch = "W";
      {SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_PAD }: r.ch = "X";
      {SYM_DASH, SYM_DOT,  SYM_DASH, SYM_DASH, SYM_PAD }: r.ch = "Y";
      {SYM_DASH, SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_PAD }: r.ch = "Z";
      {SYM_DASH, SYM_DASH, SYM_DASH, SYM_DASH, SYM_DASH}: r.ch = "0";
      {SYM_DOT,  SYM_DASH, SYM_DASH, SYM_DASH, SYM_DASH}: r.ch = "1";
      {SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_DASH, SYM_DASH}: r.ch = "2";
      {SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DASH, SYM_DASH}: r.ch = "3";
      {SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DASH}: r.ch = "4";
      {SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DOT }: r.ch = "5";
      {SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_DOT }: r.ch = "6";
      {SYM_DASH, SYM_DASH, SYM_DOT,  SYM_DOT,  SYM_DOT }: r.ch = "7";
      {SYM_DASH, SYM_DASH, SYM_DASH, SYM_DOT,  SYM_DOT }: r.ch = "8";
      {SYM_DASH, SYM_DASH, SYM_DASH, SYM_DASH, SYM_DOT }: r.ch = "9";
      default:   r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// First-word-fall-through character FIFO; each entry is {error flag, char}.
module morse_char_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [8:0]               wdata,
  input  logic                     pop,
  output logic [8:0]               rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is forced to zero while empty so stale entries never leak out.
  assign valid = (count_q != '0);
  assign rdata = valid ? mem_q[rd_ptr_q] : '0;
  assign level = count_q;

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse code-word stream decoder: one-entry decode stage, character FIFO and
// a shifting line packer fed by consumer pops.
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int SYM_N      = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int LINE_CHARS = 16,
  parameter int DROP_NULL  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*SYM_N-1:0]            in_code,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_char,
  output logic                          out_err,
  output logic [8*LINE_CHARS-1:0]       line_data,
  output logic                          line_valid,
  input  logic                          line_clear,
  output logic [15:0]                   err_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(LINE_CHARS) + 1;
  localparam int LB = 8 * LINE_CHARS;

  logic          tail_pad;
  morse_char_t   dec;
  logic          accept, load, pop;
  logic          stage_valid_q, stage_valid_d;
  morse_char_t   stage_q, stage_d;
  logic          in_ready_q, in_ready_d;
  logic [15:0]   err_count_q, err_count_d;
  logic [LB-1:0] line_data_q, line_data_d;
  logic [CW-1:0] line_cnt_q, line_cnt_d;
  logic          line_valid_q, line_valid_d;
  logic [LW:0]   occ_d;
  logic [8:0]    fifo_rdata;

  // Slots beyond the fifth carry no meaning and must be pad for a match.
  always_comb begin
    tail_pad = 1'b1;
    for (int i = 5; i < SYM_N; i++) begin
      if (in_code[2*(SYM_N-1-i) +: 2] != SYM_PAD) tail_pad = 1'b0;
    end
    dec = morse_decode5(in_code[2*SYM_N-1 -: 10]);
    if (!tail_pad) begin
      dec.err = 1'b1;
      dec.ch  = ASCII_QMARK;
    end
  end

  always_comb begin
    accept        = in_valid & in_ready_q;
    pop           = out_valid & out_ready;
    load          = accept & ~((DROP_NULL != 0) & ~dec.err & (dec.ch == ASCII_NULL));
    stage_valid_d = load;
    stage_d       = load ? dec : '0;
    err_count_d   = err_count_q
                  + 16'(accept && dec.err && (err_count_q != 16'hFFFF));
    // The stage always drains into the FIFO, so admission only has to leave
    // one slot for whatever the stage holds after this edge.
    occ_d         = {1'b0, fifo_level} + (LW+1)'(stage_valid_q)
                  - (LW+1)'(pop) + (LW+1)'(stage_valid_d);
    in_ready_d    = occ_d < (LW+1)'(FIFO_DEPTH);
  end

  always_comb begin
    line_data_d  = line_data_q;
    line_cnt_d   = line_cnt_q;
    line_valid_d = 1'b0;
    if (line_clear) begin
      line_data_d = '0;
      line_cnt_d  = '0;
      if (pop) begin
        line_data_d = {{(LB-8){1'b0}}, out_char};
        line_cnt_d  = CW'(1);
      end
    end else if (pop) begin
      line_data_d = {line_data_q[LB-9:0], out_char};
      if (line_cnt_q == CW'(LINE_CHARS-1)) begin
        line_cnt_d   = '0;
        line_valid_d = 1'b1;
      end else begin
        line_cnt_d   = line_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
      in_ready_q    <= 1'b0;
      err_count_q   <= '0;
      line_data_q   <= '0;
      line_cnt_q    <= '0;
      line_valid_q  <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_q       <= stage_d;
      in_ready_q    <= in_ready_d;
      err_count_q   <= err_count_d;
      line_data_q   <= line_data_d;
      line_cnt_q    <= line_cnt_d;
      line_valid_q  <= line_valid_d;
    end
  end

  morse_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stage_valid_q),
    .wdata (stage_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (out_valid),
    .level (fifo_level)
  );

  assign out_err    = fifo_rdata[8];
  assign out_char   = fifo_rdata[7:0];
  assign in_ready   = in_ready_q;
  assign line_data  = line_data_q;
  assign line_valid = line_valid_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Self-checking bench: directed scenarios plus randomized streams compared
// against a string-table Morse reference model.
module tb_morse_stream_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, out_ready, line_clear;
  logic [9:0]   in_code;
  logic         in_ready, out_valid, out_err, line_valid;
  logic [7:0]   out_char;
  logic [127:0] line_data;
  logic [15:0]  err_count;
  logic [3:0]   fifo_level;
  logic         n_in_ready, n_out_valid, n_out_err, n_line_valid;
  logic [7:0]   n_out_char;
  logic [127:0] n_line_data;
  logic [15:0]  n_err_count;
  logic [3:0]   n_fifo_level;

  morse_stream_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .out_err(out_err), .line_data(line_data),
    .line_valid(line_valid), .line_clear(line_clear),
    .err_count(err_count), .fifo_level(fifo_level));

  morse_stream_decoder #(.DROP_NULL(0)) dut_nn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_code(in_code), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_char(n_out_char), .out_err(n_out_err), .line_data(n_line_data),
    .line_valid(n_line_valid), .line_clear(line_clear),
    .err_count(n_err_count), .fifo_level(n_fifo_level));

  int checks = 0;
  int failures = 0;

  string MORSE [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
    "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...",
    "-", "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
    "...--", "....-", ".....", "-....", "--...", "---..", "----."};
  string CHARS = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  logic [9:0]   in_q [$];
  logic [8:0]   got_q [$];
  int           lv_pos [$];
  logic [127:0] lv_data [$];

  function automatic logic [9:0] enc(input string m);
    logic [9:0] c;
    c = '1;
    for (int i = 0; i < m.len(); i++) c[9-2*i -: 2] = (m[i] == 8'h2D) ? 2'b01 : 2'b00;
    return c;
  endfunction

  // Reference: read the dots/dashes as text and look the string up.
  function automatic logic [8:0] ref_decode(input logic [9:0] code);
    string s;
    bit ended, bad;
    logic [1:0] sym;
    s = ""; ended = 0; bad = 0;
    if (code == 10'b10_1111_1111) return {1'b0, 8'h20};
    if (code == 10'b11_1111_1111) return 9'h000;
    for (int i = 0; i < 5; i++) begin
      sym = code[9-2*i -: 2];
      if (sym == 2'b11) ended = 1;
      else if (ended || sym == 2'b10) bad = 1;
      else if (sym == 2'b01) s = {s, "-"};
      else s = {s, "."};
    end
    if (!bad)
      for (int j = 0; j < 36; j++)
        if (MORSE[j] == s) return {1'b0, CHARS[j]};
    return {1'b1, 8'h3F};
  endfunction

  task automatic do_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; line_clear = 0; in_code = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic drive_stream(input int vpct, input int rpct, input int budget,
                              output int cyc, output bit to);
    int idle;
    bit acc, pp;
    logic [8:0] pv;
    logic [9:0] dummy;
    got_q.delete(); lv_pos.delete(); lv_data.delete();
    cyc = 0; idle = 0; to = 0;
    while (idle < 4) begin
      in_valid = (in_q.size() > 0) && ($urandom_range(99) < vpct);
      if (in_q.size() > 0) in_code = in_q[0];
      out_ready = (in_q.size() == 0) || ($urandom_range(99) < rpct);
      acc = in_valid && in_ready;
      pp  = out_valid && out_ready;
      pv  = {out_err, out_char};
      @(posedge clk); #1;
      if (acc) dummy = in_q.pop_front();
      if (pp) got_q.push_back(pv);
      if (line_valid) begin
        lv_pos.push_back(got_q.size());
        lv_data.push_back(line_data);
      end
      if (in_q.size() == 0 && !out_valid) idle++; else idle = 0;
      cyc++;
      if (cyc > budget) begin to = 1; break; end
    end
    in_valid = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_code = enc(".-"); out_ready = 1; line_clear = 0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, out_err, line_valid} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {in_ready, out_valid, out_err, line_valid});
    end
    checks++;
    if (out_char !== 8'h00) begin failures++; $display("FAIL reset_out_char got=%h exp=00", out_char); end
    checks++;
    if (line_data !== '0) begin failures++; $display("FAIL reset_line_data got=%h exp=0", line_data); end
    checks++;
    if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err_count got=%h exp=0", err_count); end
    checks++;
    if (fifo_level !== 4'h0) begin failures++; $display("FAIL reset_fifo_level got=%0d exp=0", fifo_level); end
    in_valid = 0; rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    in_code = 10'b0001111111; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_err, out_char} !== {1'b1, 1'b0, 8'h41}) begin
      failures++; $display("FAIL single_out got=%b/%b/%h exp=1/0/41", out_valid, out_err, out_char);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      failures++; $display("FAIL single_drain got=%b/%0d exp=0/0", out_valid, fifo_level);
    end
    out_ready = 0;
  endtask

  task automatic test_alnum_back_to_back();
    int cyc;
    bit to;
    do_reset();
    in_q.delete();
    for (int i = 0; i < 36; i++) in_q.push_back(enc(MORSE[i]));
    in_q.push_back(10'b1011111111);
    drive_stream(100, 100, 300, cyc, to);
    checks++;
    if (to || got_q.size() != 37) begin
      failures++; $display("FAIL alnum_count got=%0d exp=37 timeout=%0d", got_q.size(), to);
    end else begin
      for (int i = 0; i < 37; i++) begin
        logic [8:0] e;
        e = (i < 36) ? {1'b0, CHARS[i]} : 9'h020;
        checks++;
        if (got_q[i] !== e) begin failures++; $display("FAIL alnum_char[%0d] got=%h exp=%h", i, got_q[i], e); end
      end
    end
    checks++;
    if (err_count !== 16'd0) begin failures++; $display("FAIL alnum_err_count got=%0d exp=0", err_count); end
    checks++;
    if (cyc != 42) begin failures++; $display("FAIL alnum_throughput got=%0d cycles exp=42", cyc); end
  endtask

  task automatic test_random();
    logic [8:0] exp_q [$];
    logic [9:0] c;
    logic [8:0] d;
    int exp_err, cyc, k;
    bit to;
    do_reset();
    in_q.delete(); exp_err = 0;
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(9);
      if (k < 4) c = enc(MORSE[$urandom_range(35)]);
      else if (k == 4) c = 10'b1011111111;
      else if (k == 5) c = 10'b1111111111;
      else c = 10'($urandom);
      d = ref_decode(c);
      if (d[8]) exp_err++;
      if (d != 9'h000) exp_q.push_back(d);
      in_q.push_back(c);
    end
    drive_stream(70, 50, 3000, cyc, to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL random_count got=%0d exp=%0d timeout=%0d", got_q.size(), exp_q.size(), to);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_char[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++;
    if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL random_err_count got=%0d exp=%0d", err_count, exp_err); end
  endtask

  task automatic test_unmatched();
    int n, cyc;
    do_reset();
    in_code = 10'b1000000000; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_err, out_char} !== {1'b1, 1'b1, 8'h3F} || err_count !== 16'd1) begin
      failures++; $display("FAIL unmatched_out got=%b/%b/%h cnt=%0d exp=1/1/3f cnt=1", out_valid, out_err, out_char, err_count);
    end
    n = 1; cyc = 0; in_valid = 1;
    while (n < 70000 && cyc < 80000) begin
      if (in_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    repeat (3) @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (n < 70000) begin failures++; $display("FAIL unmatched_timeout got=%0d accepts exp=70000", n); end
    checks++;
    if (err_count !== 16'hFFFF) begin failures++; $display("FAIL unmatched_saturate got=%h exp=ffff", err_count); end
  endtask

  task automatic test_backpressure();
    logic [9:0] sent [$];
    logic [8:0] got [$];
    logic [9:0] cur;
    logic [8:0] pv;
    int acc_n, acc2;
    bit acc, pp;
    do_reset();
    cur = enc(MORSE[$urandom_range(35)]);
    acc_n = 0; out_ready = 0; in_valid = 1;
    for (int c = 0; c < 20; c++) begin
      in_code = cur; acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin sent.push_back(cur); acc_n++; cur = enc(MORSE[$urandom_range(35)]); end
    end
    checks++;
    if (acc_n != 8) begin failures++; $display("FAIL bp_accepted got=%0d exp=8", acc_n); end
    checks++;
    if (in_ready !== 1'b0 || fifo_level !== 4'd8) begin
      failures++; $display("FAIL bp_full got=%b/%0d exp=0/8", in_ready, fifo_level);
    end
    out_ready = 1; in_code = cur; pp = out_valid; pv = {out_err, out_char}; acc = in_ready;
    @(posedge clk); #1;
    out_ready = 0;
    if (pp) got.push_back(pv);
    if (acc) begin sent.push_back(cur); cur = enc(MORSE[$urandom_range(35)]); end
    acc2 = acc ? 1 : 0;
    for (int c = 0; c < 6; c++) begin
      in_code = cur; acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin sent.push_back(cur); acc2++; cur = enc(MORSE[$urandom_range(35)]); end
    end
    checks++;
    if (acc2 != 1) begin failures++; $display("FAIL bp_one_more got=%0d exp=1", acc2); end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 15; c++) begin
      pp = out_valid; pv = {out_err, out_char};
      @(posedge clk); #1;
      if (pp) got.push_back(pv);
    end
    out_ready = 0;
    checks++;
    if (got.size() != sent.size() || got.size() != 9) begin
      failures++; $display("FAIL bp_count got=%0d exp=9 sent=%0d", got.size(), sent.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (got[i] !== ref_decode(sent[i])) begin
          failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got[i], ref_decode(sent[i]));
        end
      end
    end
  endtask

  task automatic test_null();
    logic [9:0] codes [3];
    logic [8:0] g1 [$];
    logic [8:0] g2 [$];
    logic [8:0] c1, c2;
    int idx;
    bit acc, p1, p2;
    do_reset();
    codes[0] = enc(".-"); codes[1] = 10'b1111111111; codes[2] = enc("-...");
    idx = 0; out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) in_code = codes[idx];
      acc = in_valid && in_ready;
      p1 = out_valid; c1 = {out_err, out_char};
      p2 = n_out_valid; c2 = {n_out_err, n_out_char};
      @(posedge clk); #1;
      if (acc) idx++;
      if (p1) g1.push_back(c1);
      if (p2) g2.push_back(c2);
    end
    in_valid = 0; out_ready = 0;
    checks++;
    if (g1.size() != 2 || g1[0] !== 9'h041 || g1[1] !== 9'h042) begin
      failures++; $display("FAIL null_drop got_n=%0d exp A,B", g1.size());
    end
    checks++;
    if (g2.size() != 3 || g2[0] !== 9'h041 || g2[1] !== 9'h000 || g2[2] !== 9'h042) begin
      failures++; $display("FAIL null_pass got_n=%0d exp A,00,B", g2.size());
    end
  endtask

  task automatic test_line();
    logic [127:0] p;
    logic [9:0] cx;
    logic [8:0] d;
    int cyc;
    bit to;
    do_reset();
    in_q.delete(); p = '0;
    for (int i = 0; i < 16; i++) begin
      in_q.push_back(enc(MORSE[$urandom_range(35)]));
      d = ref_decode(in_q[i]);
      p = {p[119:0], d[7:0]};
    end
    drive_stream(80, 60, 500, cyc, to);
    checks++;
    if (to || lv_pos.size() != 1 || lv_pos[0] != 16) begin
      failures++; $display("FAIL line_pulse got=%0d pulses exp=1 at pop 16 timeout=%0d", lv_pos.size(), to);
    end else begin
      checks++;
      if (lv_data[0] !== p) begin failures++; $display("FAIL line_data got=%h exp=%h", lv_data[0], p); end
    end
    checks++;
    if (line_data !== p) begin failures++; $display("FAIL line_hold got=%h exp=%h", line_data, p); end
    cx = enc(MORSE[$urandom_range(35)]);
    d = ref_decode(cx);
    in_code = cx; in_valid = 1; out_ready = 0;
    for (int c = 0; c < 6 && !out_valid; c++) begin
      if (in_ready) begin @(posedge clk); #1; in_valid = 0; end
      else begin @(posedge clk); #1; end
    end
    in_valid = 0;
    out_ready = 1; line_clear = 1;
    @(posedge clk); #1;
    out_ready = 0; line_clear = 0;
    checks++;
    if (line_data !== {120'b0, d[7:0]} || line_valid !== 1'b0) begin
      failures++; $display("FAIL line_clear_pop got=%h/%b exp=%h/0", line_data, line_valid, {120'b0, d[7:0]});
    end
    p = {120'b0, d[7:0]};
    in_q.delete();
    for (int i = 0; i < 15; i++) begin
      in_q.push_back(enc(MORSE[$urandom_range(35)]));
      d = ref_decode(in_q[i]);
      p = {p[119:0], d[7:0]};
    end
    drive_stream(100, 70, 500, cyc, to);
    checks++;
    if (to || lv_pos.size() != 1 || lv_pos[0] != 15) begin
      failures++; $display("FAIL line_after_clear got=%0d pulses exp=1 at pop 15", lv_pos.size());
    end else begin
      checks++;
      if (lv_data[0] !== p) begin failures++; $display("FAIL line_after_clear_data got=%h exp=%h", lv_data[0], p); end
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit to;
    do_reset();
    in_q.delete();
    for (int i = 0; i < 3; i++) in_q.push_back(enc(MORSE[$urandom_range(35)]));
    in_q.push_back(10'b1000000000);
    drive_stream(100, 100, 200, cyc, to);
    in_valid = 1; out_ready = 0; in_code = enc("...");
    repeat (5) @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, out_err, line_valid, out_char, line_data, err_count, fifo_level} !== '0) begin
      failures++; $display("FAIL midreset_outputs got=%b/%b/%h/%h/%h/%0d exp=all zero",
                           in_ready, out_valid, out_char, line_data, err_count, fifo_level);
    end
    in_valid = 0; rst_n = 1;
    repeat (4) @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      failures++; $display("FAIL midreset_residue got=%b/%0d exp=0/0", out_valid, fifo_level);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alnum_back_to_back();
    test_random();
    test_unmatched();
    test_backpressure();
    test_null();
    test_line();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
